// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply engine: controller states and drain length.
package matmul_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
   localparam int DRAIN_CYCLES = 3;
endpackage

// File: rtl/matmul_engine_mac_pipe.sv
// Multiply-accumulate back end: S1 multiply, S2 accumulate, S3 registered C write.
module mac_pipe #(
   parameter int LOG2N  = 6,
   parameter int DW     = 8,
   parameter int ACCW   = 2*DW+LOG2N,
   parameter int SIGNED = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 issue_vld,
   input  logic [3*LOG2N-1:0]   issue_tag,
   input  logic [DW-1:0]        a_dout,
   input  logic [DW-1:0]        b_dout,
   output logic [2*LOG2N-1:0]   c_addr,
   output logic [ACCW-1:0]      c_din,
   output logic                 c_cen_n,
   output logic                 c_wen_n
);
   localparam int TW = 3*LOG2N;
   localparam int PW = 2*DW;
   localparam logic SX = (SIGNED != 0);
   localparam logic [LOG2N-1:0] K_LAST = '1;

   logic [2:1]          vld_pipe;
   logic [2:1][TW-1:0]  tag_pipe;
   logic [PW-1:0]       a_ext, b_ext, prod_q;
   logic [ACCW-1:0]     p_ext, acc, acc_nxt;

   // Extending both operands to PW bits makes the low PW bits of the product
   // the correct signed or unsigned result.
   assign a_ext   = {{DW{SX & a_dout[DW-1]}}, a_dout};
   assign b_ext   = {{DW{SX & b_dout[DW-1]}}, b_dout};
   assign p_ext   = {{(ACCW-PW){SX & prod_q[PW-1]}}, prod_q};
   assign acc_nxt = ((tag_pipe[2][LOG2N-1:0] == '0) ? '0 : acc) + p_ext;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
         tag_pipe <= '0;
         prod_q   <= '0;
         acc      <= '0;
         c_addr   <= '0;
         c_din    <= '0;
         c_cen_n  <= 1'b1;
         c_wen_n  <= 1'b1;
      end else begin
         vld_pipe <= {vld_pipe[1], issue_vld};
         tag_pipe <= {tag_pipe[1], issue_tag};
         c_cen_n  <= 1'b1;
         c_wen_n  <= 1'b1;
         if (vld_pipe[1]) prod_q <= a_ext * b_ext;
         if (vld_pipe[2]) begin
            acc <= acc_nxt;
            if (tag_pipe[2][LOG2N-1:0] == K_LAST) begin
               c_addr  <= tag_pipe[2][TW-1:LOG2N];
               c_din   <= acc_nxt;
               c_cen_n <= 1'b0;
               c_wen_n <= 1'b0;
            end
         end
      end
   end
endmodule

// File: rtl/matmul_engine.sv
// N x N matrix-multiply controller: walks {i,j,k}, reads A/B SRAMs, streams C writes.
module matmul_engine
   import matmul_pkg::*;
#(
   parameter int LOG2N  = 6,
   parameter int DW     = 8,
   parameter int ACCW   = 2*DW+LOG2N,
   parameter int SIGNED = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic [2*LOG2N-1:0]   a_addr,
   output logic                 a_cen_n,
   input  logic [DW-1:0]        a_dout,
   output logic [2*LOG2N-1:0]   b_addr,
   output logic                 b_cen_n,
   input  logic [DW-1:0]        b_dout,
   output logic [2*LOG2N-1:0]   c_addr,
   output logic [ACCW-1:0]      c_din,
   output logic                 c_cen_n,
   output logic                 c_wen_n
);
   localparam int L  = LOG2N;
   localparam int CW = 3*LOG2N;
   localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES-1);

   state_e          state;
   logic [CW-1:0]   cnt;
   logic [1:0]      drain_cnt;
   logic            rd_cen_n;

   // cnt = {i,j,k}; it holds the index whose reads are on the bus this cycle
   assign a_addr  = {cnt[CW-1 -: L], cnt[L-1:0]};
   assign b_addr  = {cnt[L-1:0], cnt[2*L-1 -: L]};
   assign a_cen_n = rd_cen_n;
   assign b_cen_n = rd_cen_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         drain_cnt <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rd_cen_n  <= 1'b1;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               state    <= RUN;
               cnt      <= '0;
               busy     <= 1'b1;
               rd_cen_n <= 1'b0;
            end
            RUN: begin
               cnt <= cnt + CW'(1);
               if (&cnt) begin
                  state     <= DRAIN;
                  drain_cnt <= '0;
                  rd_cen_n  <= 1'b1;
               end
            end
            DRAIN: begin
               drain_cnt <= drain_cnt + 2'd1;
               if (drain_cnt == DRAIN_LAST) begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   mac_pipe #(.LOG2N(LOG2N), .DW(DW), .ACCW(ACCW), .SIGNED(SIGNED)) u_mac (
      .clk       (clk),
      .rst       (rst),
      .issue_vld (~rd_cen_n),
      .issue_tag (cnt),
      .a_dout    (a_dout),
      .b_dout    (b_dout),
      .c_addr    (c_addr),
      .c_din     (c_din),
      .c_cen_n   (c_cen_n),
      .c_wen_n   (c_wen_n)
   );
endmodule

// File: tb/tb_matmul_engine.sv
// Bench: unsigned N=4 engine and signed N=8 engine against a golden model via C-write scoreboards.
module tb_matmul_engine;
   localparam int UL = 2, UN = 4, UE = 16, UACC = 20;
   localparam int SL = 3, SN = 8, SE = 64, SACC = 19;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic u_start = 1'b0, u_busy, u_done, u_a_cen_n, u_b_cen_n, u_c_cen_n, u_c_wen_n;
   logic [2*UL-1:0] u_a_addr, u_b_addr, u_c_addr;
   logic [7:0] u_a_dout = '0, u_b_dout = '0;
   logic [UACC-1:0] u_c_din;

   logic s_start = 1'b0, s_busy, s_done, s_a_cen_n, s_b_cen_n, s_c_cen_n, s_c_wen_n;
   logic [2*SL-1:0] s_a_addr, s_b_addr, s_c_addr;
   logic [7:0] s_a_dout = '0, s_b_dout = '0;
   logic [SACC-1:0] s_c_din;

   matmul_engine #(.LOG2N(UL), .DW(8), .ACCW(UACC), .SIGNED(0)) dut_u (
      .clk(clk), .rst(rst), .start(u_start), .busy(u_busy), .done(u_done),
      .a_addr(u_a_addr), .a_cen_n(u_a_cen_n), .a_dout(u_a_dout),
      .b_addr(u_b_addr), .b_cen_n(u_b_cen_n), .b_dout(u_b_dout),
      .c_addr(u_c_addr), .c_din(u_c_din), .c_cen_n(u_c_cen_n), .c_wen_n(u_c_wen_n));

   matmul_engine #(.LOG2N(SL), .DW(8), .ACCW(SACC), .SIGNED(1)) dut_s (
      .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
      .a_addr(s_a_addr), .a_cen_n(s_a_cen_n), .a_dout(s_a_dout),
      .b_addr(s_b_addr), .b_cen_n(s_b_cen_n), .b_dout(s_b_dout),
      .c_addr(s_c_addr), .c_din(s_c_din), .c_cen_n(s_c_cen_n), .c_wen_n(s_c_wen_n));

   // sync-read A/B SRAM models, one cycle latency
   logic [7:0] ua[UE], ub[UE], sa[SE], sb[SE];
   always @(posedge clk) begin
      if (!u_a_cen_n) u_a_dout <= ua[u_a_addr];
      if (!u_b_cen_n) u_b_dout <= ub[u_b_addr];
      if (!s_a_cen_n) s_a_dout <= sa[s_a_addr];
      if (!s_b_cen_n) s_b_dout <= sb[s_b_addr];
   end

   typedef struct {logic [11:0] addr; logic [31:0] data;} exp_t;
   exp_t uq[$], sq[$];
   exp_t ue, se;
   int pass_cnt = 0, tot_cnt = 0;
   int u_wr = 0, u_dn = 0, u_bz = 0, s_wr = 0, s_dn = 0, s_bz = 0;
   logic [31:0] s_first = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   // C side: every write must match the head of the scoreboard
   always @(negedge clk) begin
      if (u_c_cen_n === 1'b0 && u_c_wen_n === 1'b0) begin
         u_wr++;
         chk("u_sb_has_entry", 32'(uq.size() != 0), 32'd1);
         if (uq.size() != 0) begin
            ue = uq.pop_front();
            chk("u_c_addr", 32'(u_c_addr), 32'(ue.addr));
            chk("u_c_din", 32'(u_c_din), ue.data);
         end
      end
      if (s_c_cen_n === 1'b0 && s_c_wen_n === 1'b0) begin
         if (s_wr == 0) s_first = 32'(s_c_din);
         s_wr++;
         chk("s_sb_has_entry", 32'(sq.size() != 0), 32'd1);
         if (sq.size() != 0) begin
            se = sq.pop_front();
            chk("s_c_addr", 32'(s_c_addr), 32'(se.addr));
            chk("s_c_din", 32'(s_c_din), se.data);
         end
      end
      if (u_done) u_dn++;
      if (u_busy) u_bz++;
      if (s_done) s_dn++;
      if (s_busy) s_bz++;
   end

   function automatic logic [7:0] elem(input int m, input int idx, input int n, input logic [7:0] v);
      case (m)
         0:       return (idx / n == idx % n) ? 8'd1 : 8'd0;
         1:       return 8'(idx);
         2:       return v;
         default: return 8'($urandom);
      endcase
   endfunction

   task automatic fill_u(input int am, input int bm, input logic [7:0] av, input logic [7:0] bv);
      for (int x = 0; x < UE; x++) begin
         ua[x] = elem(am, x, UN, av);
         ub[x] = elem(bm, x, UN, bv);
      end
   endtask

   task automatic fill_s(input int am, input int bm, input logic [7:0] av, input logic [7:0] bv);
      for (int x = 0; x < SE; x++) begin
         sa[x] = elem(am, x, SN, av);
         sb[x] = elem(bm, x, SN, bv);
      end
   endtask

   task automatic push_u();
      exp_t e;
      for (int i = 0; i < UN; i++)
         for (int j = 0; j < UN; j++) begin
            int s = 0;
            for (int k = 0; k < UN; k++) s += int'(ua[i*UN+k]) * int'(ub[k*UN+j]);
            e.addr = 12'(i*UN + j);
            e.data = 32'(s) & ((32'd1 << UACC) - 1);
            uq.push_back(e);
         end
   endtask

   task automatic push_s();
      exp_t e;
      for (int i = 0; i < SN; i++)
         for (int j = 0; j < SN; j++) begin
            int s = 0;
            for (int k = 0; k < SN; k++) s += int'($signed(sa[i*SN+k])) * int'($signed(sb[k*SN+j]));
            e.addr = 12'(i*SN + j);
            e.data = 32'(s) & ((32'd1 << SACC) - 1);
            sq.push_back(e);
         end
   endtask

   // One run on the unsigned engine; ghost=1 also pulses start in RUN, DRAIN and the done cycle.
   task automatic run_u(input string nm, input int ghost, input int exp_lat, input int exp_busy,
                        input int exp_wr);
      int c;
      u_wr = 0; u_dn = 0; u_bz = 0;
      push_u();
      @(negedge clk) u_start = 1'b1;
      for (c = 0; c < 400; c++) begin
         @(negedge clk);
         u_start = (ghost != 0) && (c == 10 || c == 65 || c == 67);
         if (u_done) break;
      end
      chk({nm, "_done_latency"}, 32'(c), 32'(exp_lat));
      @(negedge clk) u_start = 1'b0;
      repeat (8) @(negedge clk);
      chk({nm, "_busy_cycles"}, 32'(u_bz), 32'(exp_busy));
      chk({nm, "_done_pulses"}, 32'(u_dn), 32'd1);
      chk({nm, "_writes"}, 32'(u_wr), 32'(exp_wr));
      chk({nm, "_sb_left"}, 32'(uq.size()), 32'd0);
   endtask

   task automatic run_s(input string nm);
      int c;
      s_wr = 0; s_dn = 0; s_bz = 0;
      push_s();
      @(negedge clk) s_start = 1'b1;
      for (c = 0; c < 1200; c++) begin
         @(negedge clk);
         s_start = 1'b0;
         if (s_done) break;
      end
      chk({nm, "_done_latency"}, 32'(c), 32'(SN*SN*SN + 3));
      repeat (4) @(negedge clk);
      chk({nm, "_busy_cycles"}, 32'(s_bz), 32'(SN*SN*SN + 3));
      chk({nm, "_done_pulses"}, 32'(s_dn), 32'd1);
      chk({nm, "_writes"}, 32'(s_wr), 32'(SN*SN));
      chk({nm, "_sb_left"}, 32'(sq.size()), 32'd0);
   endtask

   typedef struct {
      string nm; int am; int bm; logic [7:0] av; logic [7:0] bv; int ghost;
      int exp_lat; int exp_busy; int exp_wr;
   } vec_t;
   vec_t tbl[4];

   initial begin
      // modes: 0 identity, 1 index pattern (4r+c), 2 constant, 3 random
      tbl[0] = '{"ident",  0, 1, 8'd0,   8'd0,   0, 67, 67, 16};
      tbl[1] = '{"rand0",  3, 3, 8'd0,   8'd0,   0, 67, 67, 16};
      tbl[2] = '{"rand1",  3, 3, 8'd0,   8'd0,   0, 67, 67, 16};
      tbl[3] = '{"ghost",  2, 2, 8'd255, 8'd255, 1, 67, 67, 16};

      repeat (3) @(negedge clk);
      chk("rst_busy",    32'(u_busy),    32'd0);
      chk("rst_done",    32'(u_done),    32'd0);
      chk("rst_a_cen_n", 32'(u_a_cen_n), 32'd1);
      chk("rst_b_cen_n", 32'(u_b_cen_n), 32'd1);
      chk("rst_c_cen_n", 32'(u_c_cen_n), 32'd1);
      chk("rst_c_wen_n", 32'(u_c_wen_n), 32'd1);
      chk("rst_a_addr",  32'(u_a_addr),  32'd0);
      chk("rst_c_addr",  32'(u_c_addr),  32'd0);
      chk("rst_c_din",   32'(u_c_din),   32'd0);
      chk("rst_s_busy",  32'(s_busy),    32'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 4; v++) begin
         fill_u(tbl[v].am, tbl[v].bm, tbl[v].av, tbl[v].bv);
         run_u(tbl[v].nm, tbl[v].ghost, tbl[v].exp_lat, tbl[v].exp_busy, tbl[v].exp_wr);
      end

      // signed extremes: every C = 8 * (-128*127) = -130048 in 19 bits
      fill_s(2, 2, 8'h80, 8'h7f);
      run_s("s_const");
      chk("s_const_c00", s_first, 32'h60400);
      fill_s(3, 3, 8'd0, 8'd0);
      run_s("s_rand0");
      fill_s(3, 3, 8'd0, 8'd0);
      run_s("s_rand1");

      // reset in the middle of a run, then a fresh run must complete
      fill_u(3, 3, 8'd0, 8'd0);
      push_u();
      u_dn = 0;
      @(negedge clk) u_start = 1'b1;
      @(negedge clk) u_start = 1'b0;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_a_cen_n", 32'(u_a_cen_n), 32'd1);
      chk("midrst_b_cen_n", 32'(u_b_cen_n), 32'd1);
      chk("midrst_c_cen_n", 32'(u_c_cen_n), 32'd1);
      chk("midrst_c_wen_n", 32'(u_c_wen_n), 32'd1);
      chk("midrst_busy",    32'(u_busy),    32'd0);
      rst = 1'b0;
      uq.delete();
      u_wr = 0;
      repeat (10) @(negedge clk);
      chk("midrst_no_writes", 32'(u_wr), 32'd0);
      chk("midrst_no_done",   32'(u_dn), 32'd0);
      fill_u(3, 3, 8'd0, 8'd0);
      run_u("after_rst", 0, 67, 67, 16);

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end
endmodule
